// File: rtl/bus_reg_slave.sv
// Write-only bus responder with shadow/active config banks, atomic commit and wait states.
// Define BUS_REG_SLAVE_AUTOCOMMIT_EN to make every register write also request a commit.
module bus_reg_slave #(
  parameter int BAW   = 8,
  parameter int BDW   = 32,
  parameter int RN    = 8,
  parameter int RBASE = 4,
  parameter int WS    = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bus_wready,
  input  logic              bus_wvalid,
  input  logic [BAW-1:0]    bus_waddr,
  input  logic [BDW-1:0]    bus_wdata,
  output logic [RN*BDW-1:0] cfg_data,
  output logic              cfg_commit,
  input  logic              cfg_busy,
  output logic              err_addr,
  output logic [1:0]        dbg_state_o
);

`ifdef BUS_REG_SLAVE_AUTOCOMMIT_EN
  localparam bit AutoCommit = 1'b1;
`else
  localparam bit AutoCommit = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic                      wready_q, wready_d;
  logic                      commit_q, commit_d;
  logic                      err_q, err_d;
  logic [RN-1:0][BDW-1:0]    shadow_q, shadow_d;
  logic [RN-1:0][BDW-1:0]    active_q, active_d;
  logic                      acc;
  logic                      req;
  logic                      hit;
  logic [31:0]               addr;

  // Handshake: a write transfers at a posedge where bus_wvalid && bus_wready; bus_wready is
  // registered, only high in IDLE with no wait states left, and drops only after a transfer.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    commit_d = 1'b0;
    err_d    = err_q;
    shadow_d = shadow_q;
    active_d = active_q;
    req      = 1'b0;
    hit      = 1'b0;
    acc      = bus_wvalid && wready_q;
    addr     = 32'(bus_waddr);

    if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;

    if (acc) begin
      wcnt_d = 4'(WS);
      if (addr == 32'd0) begin
        if (bus_wdata[1]) err_d = 1'b0;
        req = bus_wdata[0];
      end else begin
        for (int i = 0; i < RN; i++) begin
          if (addr == 32'(RBASE + i)) begin
            shadow_d[i] = bus_wdata;
            hit         = 1'b1;
          end
        end
        if (hit) req = AutoCommit;
        else     err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (req) state_d = PEND;
      PEND: begin
        if (!cfg_busy) begin
          state_d  = COMMIT;
          active_d = shadow_q;
          commit_d = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wready_d = (state_d == IDLE) && (wcnt_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wcnt_q   <= 4'd0;
      wready_q <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wready_q <= wready_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign bus_wready  = wready_q;
  assign cfg_data    = active_q;
  assign cfg_commit  = commit_q;
  assign err_addr    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Bench for bus_reg_slave: directed scenarios plus random writes, scoreboarded against a model.
module tb_bus_reg_slave;
  localparam int BAW   = 8;
  localparam int BDW   = 32;
  localparam int RN    = 8;
  localparam int RBASE = 4;
  localparam int WS    = 2;
  localparam int W     = RN * BDW;
`ifdef BUS_REG_SLAVE_AUTOCOMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  // A commit adds two non-ready cycles, so it hides wait states up to 2.
  localparam int EXP_GAP = AUTO ? ((WS > 2 ? WS : 2) + 1) : (WS + 1);

  logic           clk;
  logic           rst;
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic [W-1:0]   cfg_data;
  logic           cfg_commit;
  logic           cfg_busy;
  logic           err_addr;
  logic [1:0]     dbg_state;

  bus_reg_slave #(.BAW(BAW), .BDW(BDW), .RN(RN), .RBASE(RBASE), .WS(WS)) dut (
    .clk(clk), .rst(rst), .bus_wready(bus_wready), .bus_wvalid(bus_wvalid),
    .bus_waddr(bus_waddr), .bus_wdata(bus_wdata), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .err_addr(err_addr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int             total = 0;
  int             bad   = 0;
  logic [W-1:0]   exp_q[$];
  logic [BDW-1:0] m_shadow[RN];
  logic [W-1:0]   m_active = '0;
  logic           m_err = 1'b0;
  logic           m_pend = 1'b0;
  logic           m_acc = 1'b0;
  logic           m_rst_edge = 1'b1;
  logic           exp_commit = 1'b0;
  logic           rdy_n = 1'b0;
  logic           prev_rdy = 1'b0;
  logic           rand_busy = 1'b0;
  int             n_edge = 0;
  int             m_a;
  logic           m_req;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] snap();
    logic [W-1:0] v;
    for (int i = 0; i < RN; i++) v[i*BDW +: BDW] = m_shadow[i];
    return v;
  endfunction

  // Reference model: acts on inputs seen at each posedge (inputs change only on negedges).
  always @(posedge clk) begin
    n_edge++;
    m_acc      = 1'b0;
    exp_commit = 1'b0;
    m_rst_edge = !rst;
    if (!rst) begin
      for (int i = 0; i < RN; i++) m_shadow[i] = '0;
      m_err    = 1'b0;
      m_pend   = 1'b0;
      m_active = '0;
      exp_q.delete();
    end else begin
      if (m_pend && !cfg_busy) begin
        m_pend     = 1'b0;
        exp_commit = 1'b1;
      end
      if (bus_wvalid && rdy_n) begin
        m_acc = 1'b1;
        m_req = 1'b0;
        m_a   = int'(bus_waddr);
        if (m_a == 0) begin
          if (bus_wdata[1]) m_err = 1'b0;
          m_req = bus_wdata[0];
        end else if (m_a >= RBASE && m_a < RBASE + RN) begin
          m_shadow[m_a - RBASE] = bus_wdata;
          m_req = AUTO;
        end else begin
          m_err = 1'b1;
        end
        if (m_req) begin
          m_pend = 1'b1;
          exp_q.push_back(snap());
        end
      end
    end
  end

  // Monitor: checks outputs each negedge, pops expected bank on every commit pulse.
  always @(negedge clk) begin
    if (n_edge > 0) begin
      if (prev_rdy && !m_acc && !m_rst_edge) chk("ready_hold", bus_wready, 1'b1);
      chk("commit_pulse", cfg_commit, exp_commit);
      if (cfg_commit) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL commit_unexpected: got pulse want none queued");
        end else begin
          m_active = exp_q.pop_front();
        end
      end
      chk("cfg_data", cfg_data, m_active);
      chk("err_addr", err_addr, m_err);
    end
    prev_rdy = bus_wready;
    rdy_n    = bus_wready;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [BAW-1:0] a, input logic [BDW-1:0] d, output time t);
    int n;
    n = 0;
    @(negedge clk);
    if (rand_busy) cfg_busy = ($urandom_range(0, 3) == 0);
    bus_wvalid = 1'b1;
    bus_waddr  = a;
    bus_wdata  = d;
    while (!bus_wready && n < 200) begin
      @(negedge clk);
      if (rand_busy) cfg_busy = ($urandom_range(0, 3) == 0);
      n++;
    end
    if (!bus_wready) begin
      total++;
      bad++;
      $display("FAIL write_timeout: got no ready want ready addr=%0h", a);
      bus_wvalid = 1'b0;
      t = 0;
    end else begin
      @(posedge clk);
      t = $time;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus_wvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time t, tp;
    int  sel;
    logic [BAW-1:0] a;
    rst = 1'b0; bus_wvalid = 1'b0; bus_waddr = '0; bus_wdata = '0; cfg_busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_ready", bus_wready, 1'b0);
    chk("rst_data", cfg_data, '0);
    chk("rst_commit", cfg_commit, 1'b0);
    chk("rst_err", err_addr, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus_wready, 1'b1);

    // Shadow writes then CTRL commit
    bus_write(8'h04, 32'h76543210, t);
    bus_write(8'h05, 32'h01234567, t);
    bus_write(8'h00, 32'h1, t);
    idle();
    chk("commit_e0", cfg_commit, 1'b0);
    @(negedge clk);
    chk("commit_e1", cfg_commit, 1'b1);
    chk("reg0", cfg_data[31:0], 32'h76543210);
    chk("reg1", cfg_data[63:32], 32'h01234567);
    @(negedge clk);
    chk("ready_e2", bus_wready, 1'b1);

    // Commit deferred by busy consumer
    cfg_busy = 1'b1;
    bus_write(8'h06, 32'hcafef00d, t);
    bus_write(8'h00, 32'h1, t);
    idle();
    repeat (10) begin
      chk("busy_ready", bus_wready, 1'b0);
      chk("busy_commit", cfg_commit, 1'b0);
      @(negedge clk);
    end
    cfg_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_commit", cfg_commit, 1'b1);
    chk("busy_release_ready", bus_wready, 1'b0);
    chk("reg2", cfg_data[95:64], 32'hcafef00d);
    @(negedge clk);
    chk("busy_ready_back", bus_wready, 1'b1);

    // Unmapped addresses and error clear
    bus_write(8'h20, 32'hdeadbeef, t); idle();
    chk("err_set", err_addr, 1'b1);
    bus_write(8'h00, 32'h2, t); idle();
    chk("err_clr", err_addr, 1'b0);
    bus_write(8'(RBASE + RN), 32'h11111111, t); idle();
    chk("err_above_map", err_addr, 1'b1);
    bus_write(8'h00, 32'h3, t); idle();
    chk("err_clr_commit", err_addr, 1'b0);
    @(negedge clk);
    chk("clr_commit_pulse", cfg_commit, 1'b1);
    bus_write(8'(RBASE + RN - 1), 32'ha5a5a5a5, t); idle();
    chk("last_reg_no_err", err_addr, 1'b0);
    bus_write(8'h03, 32'h0, t); idle();
    chk("err_below_map", err_addr, 1'b1);
    bus_write(8'hff, 32'h0, t); idle();
    bus_write(8'h00, 32'h2, t); idle();

    // Back-to-back writes with valid held: wait-state spacing
    bus_write(8'h06, $urandom, tp);
    for (int i = 7; i < 10; i++) begin
      bus_write(8'(i), $urandom, t);
      chk("ws_gap", int'((t - tp) / 10), EXP_GAP);
      tp = t;
    end
    idle();
    bus_write(8'h00, 32'h1, t); idle();
    repeat (4) @(negedge clk);

    // Reset while a commit is pending
    cfg_busy = 1'b1;
    bus_write(8'h04, 32'h0badf00d, t);
    bus_write(8'h00, 32'h1, t); idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("pend_rst_data", cfg_data, '0);
    cfg_busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("pend_rst_no_commit", cfg_data, '0);
    bus_write(8'h04, 32'h13572468, t); idle();
    repeat (4) @(negedge clk);

    // Random traffic with random consumer busy
    rand_busy = 1'b1;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 8'h00;
      else if (sel == 1) a = 8'($urandom_range(RBASE + RN, 255));
      else if (sel == 2) a = 8'($urandom_range(1, RBASE - 1));
      else               a = 8'(RBASE + $urandom_range(0, RN - 1));
      bus_write(a, (a == 8'h00) ? 32'($urandom_range(0, 3)) : 32'($urandom), t);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    rand_busy = 1'b0;
    idle();
    cfg_busy = 1'b0;
    bus_write(8'h00, 32'h1, t); idle();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
